// File: rtl/nts_api_arbiter_pkg.sv
// Shared definitions for the NTS API arbiter: FSM states, master indices and
// API bus widths.
package nts_api_arbiter_pkg;

    localparam int unsigned AddrWidth = 12;
    localparam int unsigned DataWidth = 32;

    // Master indices; also the value stored in last_grant.
    localparam logic MasterHost = 1'b0;
    localparam logic MasterSeq  = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StAck   = 2'd2
    } state_e;

    // One-hot lock-owner mask for a master index.
    function automatic logic [1:0] owner_mask(input logic master);
        return master ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/nts_api_arbiter_lock_timer.sv
// Lock timeout counter.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : restart the count from zero
//   en         : count one idle cycle
//   tick       : high in the cycle whose enabled count reaches LOCK_TIMEOUT
module nts_api_arbiter_lock_timer #(
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [7:0] count_q;

    // The tick edge is the one that would take the count to LOCK_TIMEOUT.
    assign tick = en && (count_q == 8'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else if (clr || tick) begin
            count_q <= 8'd0;
        end else if (en) begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/nts_api_arbiter.sv
// Two-master round-robin arbiter with bus lock in front of the NTS API decoder.
//   i_clk, i_areset_n          : clock, asynchronous active-low reset
//   i_mN_req/we/lock/address/write_data : master N request, held until ack
//   o_mN_ack, o_mN_read_data   : completion pulse and captured read data
//   o_api_cs/we/address/write_data, i_api_read_data : decoder port
//   o_busy                     : transaction in flight (ISSUE or ACK)
//   o_lock_owner               : bit n set when master n holds the lock
//   o_lock_timeout             : one-cycle pulse when an idle lock is revoked
module nts_api_arbiter
    import nts_api_arbiter_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_areset_n,
    input  logic                 i_m0_req,
    input  logic                 i_m0_we,
    input  logic                 i_m0_lock,
    input  logic [AddrWidth-1:0] i_m0_address,
    input  logic [DataWidth-1:0] i_m0_write_data,
    output logic                 o_m0_ack,
    output logic [DataWidth-1:0] o_m0_read_data,
    input  logic                 i_m1_req,
    input  logic                 i_m1_we,
    input  logic                 i_m1_lock,
    input  logic [AddrWidth-1:0] i_m1_address,
    input  logic [DataWidth-1:0] i_m1_write_data,
    output logic                 o_m1_ack,
    output logic [DataWidth-1:0] o_m1_read_data,
    output logic                 o_api_cs,
    output logic                 o_api_we,
    output logic [AddrWidth-1:0] o_api_address,
    output logic [DataWidth-1:0] o_api_write_data,
    input  logic [DataWidth-1:0] i_api_read_data,
    output logic                 o_busy,
    output logic [1:0]           o_lock_owner,
    output logic                 o_lock_timeout
);

    state_e               state_q;
    logic [1:0]           lock_owner_q;
    logic                 last_grant_q;
    logic                 cur_master_q;
    logic                 cur_lock_q;
    logic                 api_cs_q;
    logic                 api_we_q;
    logic [AddrWidth-1:0] api_address_q;
    logic [DataWidth-1:0] api_write_data_q;
    logic                 m0_ack_q;
    logic                 m1_ack_q;
    logic [DataWidth-1:0] m0_read_data_q;
    logic [DataWidth-1:0] m1_read_data_q;
    logic                 busy_q;
    logic                 lock_timeout_q;

    logic [1:0] req;
    logic [1:0] eligible;
    logic       grant_valid;
    logic       grant_m1;
    logic       timer_en;
    logic       timer_clr;
    logic       timer_tick;

    always_comb begin
        req      = {i_m1_req, i_m0_req};
        // While a lock is held only the owner may compete.
        eligible = (lock_owner_q != 2'b00) ? (req & lock_owner_q) : req;
        grant_valid = (state_q == StIdle) && (eligible != 2'b00);
        // On a tie the master not granted last wins.
        grant_m1 = eligible[1] && (!eligible[0] || (last_grant_q == MasterHost));
        timer_en  = (state_q == StIdle) && (lock_owner_q != 2'b00)
                    && ((req & lock_owner_q) == 2'b00);
        timer_clr = (lock_owner_q == 2'b00) || grant_valid;
    end

    nts_api_arbiter_lock_timer #(
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) u_lock_timer (
        .clk  (i_clk),
        .rst_n(i_areset_n),
        .clr  (timer_clr),
        .en   (timer_en),
        .tick (timer_tick)
    );

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q          <= StIdle;
            lock_owner_q     <= 2'b00;
            last_grant_q     <= MasterSeq;
            cur_master_q     <= MasterHost;
            cur_lock_q       <= 1'b0;
            api_cs_q         <= 1'b0;
            api_we_q         <= 1'b0;
            api_address_q    <= '0;
            api_write_data_q <= '0;
            m0_ack_q         <= 1'b0;
            m1_ack_q         <= 1'b0;
            m0_read_data_q   <= '0;
            m1_read_data_q   <= '0;
            busy_q           <= 1'b0;
            lock_timeout_q   <= 1'b0;
        end else begin
            m0_ack_q       <= 1'b0;
            m1_ack_q       <= 1'b0;
            lock_timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        state_q          <= StIssue;
                        busy_q           <= 1'b1;
                        api_cs_q         <= 1'b1;
                        api_we_q         <= grant_m1 ? i_m1_we : i_m0_we;
                        api_address_q    <= grant_m1 ? i_m1_address : i_m0_address;
                        api_write_data_q <= grant_m1 ? i_m1_write_data : i_m0_write_data;
                        cur_lock_q       <= grant_m1 ? i_m1_lock : i_m0_lock;
                        cur_master_q     <= grant_m1;
                        last_grant_q     <= grant_m1;
                    end else if (timer_tick) begin
                        lock_owner_q   <= 2'b00;
                        lock_timeout_q <= 1'b1;
                    end
                end
                StIssue: begin
                    state_q  <= StAck;
                    api_cs_q <= 1'b0;
                    // Decoder data is captured for writes too.
                    if (cur_master_q == MasterSeq) begin
                        m1_ack_q       <= 1'b1;
                        m1_read_data_q <= i_api_read_data;
                    end else begin
                        m0_ack_q       <= 1'b1;
                        m0_read_data_q <= i_api_read_data;
                    end
                    lock_owner_q <= cur_lock_q ? owner_mask(cur_master_q) : 2'b00;
                end
                StAck: begin
                    state_q          <= StIdle;
                    busy_q           <= 1'b0;
                    api_we_q         <= 1'b0;
                    api_address_q    <= '0;
                    api_write_data_q <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_m0_ack         = m0_ack_q;
    assign o_m1_ack         = m1_ack_q;
    assign o_m0_read_data   = m0_read_data_q;
    assign o_m1_read_data   = m1_read_data_q;
    assign o_api_cs         = api_cs_q;
    assign o_api_we         = api_we_q;
    assign o_api_address    = api_address_q;
    assign o_api_write_data = api_write_data_q;
    assign o_busy           = busy_q;
    assign o_lock_owner     = lock_owner_q;
    assign o_lock_timeout   = lock_timeout_q;

endmodule

// File: tb/tb_nts_api_arbiter.sv
// Self-checking bench for nts_api_arbiter: directed scenarios followed by a
// randomized phase, all compared against a cycle-numbered transaction model.
module tb_nts_api_arbiter;

    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic        we;
        logic        lock;
        logic        drop;
        logic [11:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk;
    logic        areset_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  lock;
    logic [11:0] addr [2];
    logic [31:0] wdata [2];
    logic        o_m0_ack, o_m1_ack;
    logic [31:0] o_m0_read_data, o_m1_read_data;
    logic        o_api_cs, o_api_we;
    logic [11:0] o_api_address;
    logic [31:0] o_api_write_data;
    logic [31:0] api_rdata;
    logic        o_busy;
    logic [1:0]  o_lock_owner;
    logic        o_lock_timeout;

    // Decoder model.
    assign api_rdata = {20'hA5A5A, o_api_address};

    nts_api_arbiter #(
        .LOCK_TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk           (clk),
        .i_areset_n      (areset_n),
        .i_m0_req        (req[0]),
        .i_m0_we         (we[0]),
        .i_m0_lock       (lock[0]),
        .i_m0_address    (addr[0]),
        .i_m0_write_data (wdata[0]),
        .o_m0_ack        (o_m0_ack),
        .o_m0_read_data  (o_m0_read_data),
        .i_m1_req        (req[1]),
        .i_m1_we         (we[1]),
        .i_m1_lock       (lock[1]),
        .i_m1_address    (addr[1]),
        .i_m1_write_data (wdata[1]),
        .o_m1_ack        (o_m1_ack),
        .o_m1_read_data  (o_m1_read_data),
        .o_api_cs        (o_api_cs),
        .o_api_we        (o_api_we),
        .o_api_address   (o_api_address),
        .o_api_write_data(o_api_write_data),
        .i_api_read_data (api_rdata),
        .o_busy          (o_busy),
        .o_lock_owner    (o_lock_owner),
        .o_lock_timeout  (o_lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: transactions are tracked by the edge number of their grant.
    int          e;
    int          g_edge;
    int          g_m;
    logic        g_we, g_lock;
    logic [11:0] g_addr;
    logic [31:0] g_wdata;
    logic [1:0]  lock_own;
    int          idle_cnt;
    logic        last;
    logic [31:0] rd_exp [2];
    logic        exp_to;

    txn_t q0[$];
    txn_t q1[$];
    logic [1:0] drop_flag;
    logic       rand_mode;
    int         ack_log[$];
    int         cs_count;
    int         to_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic w, input logic l, input logic [11:0] a,
                                input logic [31:0] d);
        txn_t t;
        t.we = w; t.lock = l; t.drop = 1'b0; t.addr = a; t.wdata = d;
        return t;
    endfunction

    task automatic push(input int m, input txn_t t);
        if (m == 0) q0.push_back(t);
        else q1.push_back(t);
    endtask

    // Present the next queued request of any master that is free to ask.
    task automatic kick();
        txn_t t;
        for (int m = 0; m < 2; m++) begin
            if (req[m] == 1'b0 && !(g_m == m && e <= g_edge)
                && ((m == 0) ? q0.size() : q1.size()) != 0) begin
                t = (m == 0) ? q0.pop_front() : q1.pop_front();
                req[m] = 1'b1; we[m] = t.we; lock[m] = t.lock;
                addr[m] = t.addr; wdata[m] = t.wdata; drop_flag[m] = t.drop;
            end
        end
    endtask

    task automatic model_reset();
        e = 0; g_edge = -100; g_m = 0; g_we = 0; g_lock = 0; g_addr = '0; g_wdata = '0;
        lock_own = 2'b00; idle_cnt = 0; last = 1'b1; exp_to = 1'b0;
        rd_exp[0] = '0; rd_exp[1] = '0;
        ack_log.delete(); cs_count = 0; to_count = 0;
    endtask

    // Decide what the coming clock edge does, from the arbitration rules.
    task automatic predict();
        int ne;
        logic [1:0] elig;
        logic w;
        ne = e + 1;
        exp_to = 1'b0;
        if (ne >= g_edge + 3) begin
            elig = (lock_own != 2'b00) ? (req & lock_own) : req;
            if (elig != 2'b00) begin
                w = (elig == 2'b11) ? ~last : elig[1];
                g_edge = ne; g_m = w ? 1 : 0;
                g_we = we[w]; g_lock = lock[w]; g_addr = addr[w]; g_wdata = wdata[w];
                last = w; idle_cnt = 0;
            end else if (lock_own != 2'b00) begin
                idle_cnt++;
                if (idle_cnt == TIMEOUT) begin
                    lock_own = 2'b00; idle_cnt = 0; exp_to = 1'b1;
                end
            end
        end else if (ne == g_edge + 1) begin
            lock_own = g_lock ? (2'b01 << g_m) : 2'b00;
            rd_exp[g_m] = {20'hA5A5A, g_addr};
        end
    endtask

    task automatic compare_all();
        logic issue, ackc, act;
        issue = (e == g_edge);
        ackc  = (e == g_edge + 1);
        act   = issue | ackc;
        check("api_cs", 32'(o_api_cs), 32'(issue));
        check("busy", 32'(o_busy), 32'(act));
        check("api_we", 32'(o_api_we), 32'(act ? g_we : 1'b0));
        check("api_addr", 32'(o_api_address), 32'(act ? g_addr : 12'h000));
        check("api_wdata", o_api_write_data, act ? g_wdata : 32'h0);
        check("m0_ack", 32'(o_m0_ack), 32'(ackc && g_m == 0));
        check("m1_ack", 32'(o_m1_ack), 32'(ackc && g_m == 1));
        check("m0_rdata", o_m0_read_data, rd_exp[0]);
        check("m1_rdata", o_m1_read_data, rd_exp[1]);
        check("lock_owner", 32'(o_lock_owner), 32'(lock_own));
        check("lock_timeout", 32'(o_lock_timeout), 32'(exp_to));
    endtask

    task automatic drive();
        txn_t t;
        for (int m = 0; m < 2; m++) begin
            if (e == g_edge + 1 && g_m == m) req[m] = 1'b0;
            if (e == g_edge && g_m == m) begin
                if (drop_flag[m]) begin
                    req[m] = 1'b0; drop_flag[m] = 1'b0;
                end else if (rand_mode) begin
                    // Fields may change once granted; the transaction must not.
                    we[m] = 1'($urandom); lock[m] = 1'($urandom);
                    addr[m] = 12'($urandom); wdata[m] = $urandom;
                end
            end
            if (rand_mode && req[m] == 1'b0 && ((m == 0) ? q0.size() : q1.size()) == 0
                && $urandom_range(2) == 0) begin
                t = mk(1'($urandom), ($urandom_range(3) == 0), 12'($urandom), $urandom);
                t.drop = ($urandom_range(7) == 0);
                push(m, t);
            end
        end
        kick();
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        #1;
        e++;
        compare_all();
        if (o_m0_ack) ack_log.push_back(0);
        if (o_m1_ack) ack_log.push_back(1);
        if (o_api_cs) cs_count++;
        if (o_lock_timeout) to_count++;
        drive();
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic int log_code();
        int c = 0;
        foreach (ack_log[i]) c = c * 2 + ack_log[i];
        return c;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cs"}, 32'(o_api_cs), 32'h0);
        check({tag, "_busy"}, 32'(o_busy), 32'h0);
        check({tag, "_ack"}, 32'({o_m0_ack, o_m1_ack}), 32'h0);
        check({tag, "_addr"}, 32'(o_api_address), 32'h0);
        check({tag, "_wdata"}, o_api_write_data, 32'h0);
        check({tag, "_rdata"}, o_m0_read_data | o_m1_read_data, 32'h0);
        check({tag, "_owner"}, 32'(o_lock_owner), 32'h0);
        check({tag, "_timeout"}, 32'(o_lock_timeout), 32'h0);
    endtask

    task automatic sync_reset();
        areset_n = 1'b0; req = 2'b00; drop_flag = 2'b00;
        q0.delete(); q1.delete();
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        areset_n = 1'b0; req = 2'b00; we = 2'b00; lock = 2'b00;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        drop_flag = 2'b00; rand_mode = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        areset_n = 1'b1;

        // m0 single read.
        push(0, mk(1'b0, 1'b0, 12'h023, 32'h0));
        kick();
        step_n(4);
        check("t1_rdata0", o_m0_read_data, 32'hA5A5A023);
        check("t1_rdata1", o_m1_read_data, 32'h0);
        check("t1_order", 32'(log_code()), 32'b0);
        check("t1_nacks", 32'(ack_log.size()), 32'd1);
        check("t1_cs_cycles", 32'(cs_count), 32'd1);

        // Simultaneous pairs with an m0 access between them.
        sync_reset();
        push(0, mk(1'b0, 1'b0, 12'h010, 32'h0));
        push(1, mk(1'b0, 1'b0, 12'h082, 32'h0));
        kick();
        step_n(7);
        push(0, mk(1'b1, 1'b0, 12'h011, 32'h1234_5678));
        kick();
        step_n(4);
        push(0, mk(1'b0, 1'b0, 12'h012, 32'h0));
        push(1, mk(1'b1, 1'b0, 12'h083, 32'hCAFE_F00D));
        kick();
        step_n(7);
        check("t2_order", 32'(log_code()), 32'b01010);
        check("t2_nacks", 32'(ack_log.size()), 32'd5);

        // m1 locked pair of writes ahead of a waiting m0.
        ack_log.delete();
        push(1, mk(1'b1, 1'b1, 12'h081, 32'h1111_1111));
        push(1, mk(1'b1, 1'b0, 12'h082, 32'h2222_2222));
        push(0, mk(1'b0, 1'b0, 12'h040, 32'h0));
        kick();
        for (int i = 0; i < 20 && ack_log.size() == 0; i++) step();
        check("t3_owner_mid", 32'(o_lock_owner), 32'b10);
        step_n(10);
        check("t3_order", 32'(log_code()), 32'b110);
        check("t3_nacks", 32'(ack_log.size()), 32'd3);
        check("t3_owner_end", 32'(o_lock_owner), 32'b00);

        // Lock timeout: m1 locks and goes quiet while m0 waits.
        ack_log.delete(); to_count = 0;
        push(1, mk(1'b1, 1'b1, 12'h0A0, 32'h3333_3333));
        kick();
        step();
        push(0, mk(1'b0, 1'b0, 12'h0A1, 32'h0));
        kick();
        step_n(14);
        check("t4_timeouts", 32'(to_count), 32'd1);
        check("t4_order", 32'(log_code()), 32'b10);
        check("t4_nacks", 32'(ack_log.size()), 32'd2);
        check("t4_owner", 32'(o_lock_owner), 32'b00);

        // Reset during ISSUE of an m0 write while m1 waits.
        push(0, mk(1'b1, 1'b0, 12'h0B0, 32'h4444_4444));
        kick();
        step();
        check("t5_in_issue", 32'(o_api_cs), 32'h1);
        push(1, mk(1'b0, 1'b0, 12'h0B1, 32'h0));
        kick();
        areset_n = 1'b0;
        req[0] = 1'b0;
        #1;
        check_outputs_zero("t5_rst");
        @(posedge clk);
        #1;
        check_outputs_zero("t5_rst_edge");
        areset_n = 1'b1;
        model_reset();
        step_n(6);
        check("t5_order", 32'(log_code()), 32'b1);
        check("t5_nacks", 32'(ack_log.size()), 32'd1);
        check("t5_rdata1", o_m1_read_data, 32'hA5A5A0B1);

        // m0 drops req in ISSUE.
        ack_log.delete(); cs_count = 0;
        begin
            txn_t t;
            t = mk(1'b0, 1'b0, 12'h0C0, 32'h0);
            t.drop = 1'b1;
            push(0, t);
        end
        kick();
        step_n(8);
        check("t6_nacks", 32'(ack_log.size()), 32'd1);
        check("t6_order", 32'(log_code()), 32'b0);
        check("t6_cs_cycles", 32'(cs_count), 32'd1);

        // Randomized traffic.
        rand_mode = 1'b1;
        step_n(1500);
        rand_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
